// File: rtl/dm_ext_bridge.sv
// Multi-window external data-memory bridge: decodes core DM accesses into up to
// NUM_WIN 8-bit external slaves with fixed wait states, slave stretching and timeout.
module dm_ext_bridge #(
    parameter int                    NUM_WIN  = 2,
    parameter logic [NUM_WIN*16-1:0] WIN_BASE = {16'hF000, 16'hE000},
    parameter logic [NUM_WIN*16-1:0] WIN_LEN  = {16'd256, 16'd1024},
    parameter logic [NUM_WIN*4-1:0]  WIN_WS   = {4'd2, 4'd0},
    parameter int                    TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [15:0]          ramadr,
    input  logic [7:0]           ramdout,
    input  logic                 ramre,
    input  logic                 ramwe,
    output logic                 busy,
    output logic                 hit,
    output logic [7:0]           rdata,
    output logic [15:0]          ext_a,
    output logic [7:0]           ext_d_out,
    output logic [NUM_WIN-1:0]   ext_cs,
    output logic                 ext_oe,
    output logic                 ext_we,
    input  logic [NUM_WIN*8-1:0] ext_d_in,
    input  logic [NUM_WIN-1:0]   ext_wait,
    output logic                 err,
    output logic [2:0]           err_win,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t               state_q, state_d;
    logic [2:0]           win_q, win_d;
    logic                 wr_q, wr_d;
    logic [3:0]           wscnt_q, wscnt_d;
    logic [15:0]          tcnt_q, tcnt_d;
    logic [15:0]          ext_a_q, ext_a_d;
    logic [7:0]           ext_d_q, ext_d_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [NUM_WIN-1:0]   cs_q, cs_d;
    logic                 oe_q, oe_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [2:0]           err_win_q, err_win_d;

    logic                 match_any;
    logic [2:0]           match_idx;
    logic [16:0]          win_lo, win_hi;
    logic [7:0]           wait_pad;
    logic [63:0]          din_pad;
    logic [31:0]          ws_pad;
    logic [7:0]           onehot;

    // Scan from the top index down so the lowest matching window wins on overlap.
    always_comb begin
        match_any = 1'b0;
        match_idx = 3'd0;
        win_lo    = 17'd0;
        win_hi    = 17'd0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            win_lo = {1'b0, WIN_BASE[16*i +: 16]};
            win_hi = win_lo + {1'b0, WIN_LEN[16*i +: 16]};
            if (({1'b0, ramadr} >= win_lo) && ({1'b0, ramadr} < win_hi)) begin
                match_any = 1'b1;
                match_idx = 3'(i);
            end
        end
    end

    // Pad per-window vectors to the 8-window maximum so a 3-bit index is always legal.
    always_comb begin
        wait_pad                  = '0;
        wait_pad[NUM_WIN-1:0]     = ext_wait;
        din_pad                   = '0;
        din_pad[NUM_WIN*8-1:0]    = ext_d_in;
        ws_pad                    = '0;
        ws_pad[NUM_WIN*4-1:0]     = WIN_WS;
        onehot                    = 8'b1 << match_idx;
    end

    assign hit  = match_any && (ramre || ramwe);
    assign busy = hit && (state_q != S_DONE);

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        wr_d      = wr_q;
        wscnt_d   = wscnt_q;
        tcnt_d    = tcnt_q;
        ext_a_d   = ext_a_q;
        ext_d_d   = ext_d_q;
        rdata_d   = rdata_q;
        cs_d      = cs_q;
        oe_d      = oe_q;
        we_d      = we_q;
        err_d     = err_q;
        err_win_d = err_win_q;

        // A timeout later in this block overrides the clear.
        if (err_clr) err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_ACCESS;
                    ext_a_d = ramadr;
                    ext_d_d = ramdout;
                    win_d   = match_idx;
                    wr_d    = ramwe;
                    wscnt_d = ws_pad[{match_idx, 2'b00} +: 4];
                    tcnt_d  = 16'd0;
                    cs_d    = onehot[NUM_WIN-1:0];
                    oe_d    = !ramwe;
                    we_d    = ramwe;
                end
            end
            S_ACCESS: begin
                if (wscnt_q != 4'd0) begin
                    wscnt_d = wscnt_q - 4'd1;
                end else if (!wait_pad[win_q]) begin
                    if (!wr_q) rdata_d = din_pad[{win_q, 3'b000} +: 8];
                    state_d = S_DONE;
                    cs_d    = '0;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                end else if (tcnt_q == TIMEOUT_C) begin
                    if (!wr_q) rdata_d = 8'hFF;
                    err_d     = 1'b1;
                    err_win_d = win_q;
                    state_d   = S_DONE;
                    cs_d      = '0;
                    oe_d      = 1'b0;
                    we_d      = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            win_q     <= 3'd0;
            wr_q      <= 1'b0;
            wscnt_q   <= 4'd0;
            tcnt_q    <= 16'd0;
            ext_a_q   <= 16'd0;
            ext_d_q   <= 8'd0;
            rdata_q   <= 8'd0;
            cs_q      <= '0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            err_win_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            wr_q      <= wr_d;
            wscnt_q   <= wscnt_d;
            tcnt_q    <= tcnt_d;
            ext_a_q   <= ext_a_d;
            ext_d_q   <= ext_d_d;
            rdata_q   <= rdata_d;
            cs_q      <= cs_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            err_q     <= err_d;
            err_win_q <= err_win_d;
        end
    end

    assign rdata     = rdata_q;
    assign ext_a     = ext_a_q;
    assign ext_d_out = ext_d_q;
    assign ext_cs    = cs_q;
    assign ext_oe    = oe_q;
    assign ext_we    = we_q;
    assign err       = err_q;
    assign err_win   = err_win_q;

endmodule

// File: tb/tb_dm_ext_bridge.sv
// Bench for dm_ext_bridge: directed accesses push expected completions into a queue;
// a negedge monitor measures each access and compares when the core would complete.
module tb_dm_ext_bridge;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] ramadr = '0;
    logic [7:0]  ramdout = '0;
    logic        ramre = 1'b0;
    logic        ramwe = 1'b0;
    logic        busy, hit;
    logic [7:0]  rdata;
    logic [15:0] ext_a;
    logic [7:0]  ext_d_out;
    logic [1:0]  ext_cs;
    logic        ext_oe, ext_we;
    logic [15:0] ext_d_in = '0;
    logic [1:0]  ext_wait = '0;
    logic        err;
    logic [2:0]  err_win;
    logic        err_clr = 1'b0;

    dm_ext_bridge dut (
        .clk(clk), .nrst(nrst), .ramadr(ramadr), .ramdout(ramdout),
        .ramre(ramre), .ramwe(ramwe), .busy(busy), .hit(hit), .rdata(rdata),
        .ext_a(ext_a), .ext_d_out(ext_d_out), .ext_cs(ext_cs), .ext_oe(ext_oe),
        .ext_we(ext_we), .ext_d_in(ext_d_in), .ext_wait(ext_wait), .err(err),
        .err_win(err_win), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] busy_cyc;
        logic [15:0] strb_cyc;
        logic        is_wr;
        logic [1:0]  cs;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rdata;
        logic        err;
        logic [2:0]  err_win;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int bc, input int sc, input logic wr, input logic [1:0] cs,
                                input logic [15:0] a, input logic [7:0] d, input logic [7:0] rd,
                                input logic e, input logic [2:0] ew);
        exp_t x;
        x.busy_cyc = 16'(bc);
        x.strb_cyc = 16'(sc);
        x.is_wr    = wr;
        x.cs       = cs;
        x.a        = a;
        x.d        = d;
        x.rdata    = rd;
        x.err      = e;
        x.err_win  = ew;
        return x;
    endfunction

    // Monitor: accumulate busy/strobe cycles per access, compare in the DONE cycle.
    int          busy_cnt = 0;
    int          oe_cnt = 0;
    int          we_cnt = 0;
    logic [1:0]  cs_seen = '0;
    logic [15:0] a_seen = '0;
    logic [7:0]  d_seen = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!nrst) begin
            busy_cnt = 0; oe_cnt = 0; we_cnt = 0; cs_seen = '0;
        end else if (busy) begin
            busy_cnt++;
            if (ext_oe) oe_cnt++;
            if (ext_we) we_cnt++;
            if (ext_cs != 2'b00) begin
                cs_seen = ext_cs; a_seen = ext_a; d_seen = ext_d_out;
            end
        end else if (hit && busy_cnt > 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got completion, expected none");
            end else begin
                mon_e = exp_t'(exp_q.pop_front());
                check("busy_cycles", busy_cnt, mon_e.busy_cyc);
                check("oe_cycles", oe_cnt, mon_e.is_wr ? 16'd0 : mon_e.strb_cyc);
                check("we_cycles", we_cnt, mon_e.is_wr ? mon_e.strb_cyc : 16'd0);
                check("ext_cs", cs_seen, mon_e.cs);
                check("ext_a", a_seen, mon_e.a);
                check("ext_d_out", d_seen, mon_e.d);
                check("rdata", rdata, mon_e.rdata);
                check("err", err, mon_e.err);
                check("err_win", err_win, mon_e.err_win);
                check("done_strobes", {ext_cs, ext_oe, ext_we}, 4'b0);
            end
            busy_cnt = 0; oe_cnt = 0; we_cnt = 0; cs_seen = '0;
        end
    end

    // Issue one access; the slave raises ext_wait for `stretch` cycles after the WS phase
    // and shows junk data while stretching.
    task automatic do_acc(input logic [15:0] addr, input logic [7:0] wd, input logic re,
                          input logic we, input int win, input int ws, input logic [7:0] din,
                          input int stretch, input exp_t e);
        int   k;
        logic done;
        exp_q.push_back(e);
        @(posedge clk); #1;
        ramadr = addr; ramdout = wd; ramre = re; ramwe = we;
        ext_wait = '0;
        ext_d_in[win*8 +: 8] = din;
        k = 0;
        done = 1'b0;
        while (!done && k < 400) begin
            @(posedge clk); #1;
            k++;
            ext_wait[win] = (k > ws) && (k <= ws + stretch);
            ext_d_in[win*8 +: 8] = ext_wait[win] ? 8'h00 : din;
            if (hit && !busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr %0h still busy after %0d cycles, expected completion", addr, k);
        end
        @(negedge clk); #1;
        ramre = 1'b0; ramwe = 1'b0; ext_wait = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ext_cs", ext_cs, 2'b00);
        check("rst_ext_oe", ext_oe, 1'b0);
        check("rst_ext_we", ext_we, 1'b0);
        check("rst_ext_a", ext_a, 16'h0000);
        check("rst_ext_d_out", ext_d_out, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_err", {err, err_win}, 4'h0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        nrst = 1'b1;

        // WS=0 read, window 0
        do_acc(16'hE005, 8'h00, 1'b1, 1'b0, 0, 0, 8'hA5, 0,
               mk(2, 1, 1'b0, 2'b01, 16'hE005, 8'h00, 8'hA5, 1'b0, 3'd0));
        // WS=2 write, window 1; rdata holds the previous read
        do_acc(16'hF010, 8'h3C, 1'b0, 1'b1, 1, 2, 8'h00, 0,
               mk(4, 3, 1'b1, 2'b10, 16'hF010, 8'h3C, 8'hA5, 1'b0, 3'd0));
        // Last byte of window 0
        do_acc(16'hE3FF, 8'h00, 1'b1, 1'b0, 0, 0, 8'h5A, 0,
               mk(2, 1, 1'b0, 2'b01, 16'hE3FF, 8'h00, 8'h5A, 1'b0, 3'd0));

        // First byte past window 0 must miss
        @(posedge clk); #1;
        ramadr = 16'hE400; ramre = 1'b1;
        #1;
        check("miss_hit", hit, 1'b0);
        check("miss_busy", busy, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("miss_strobes", {ext_cs, ext_oe, ext_we}, 4'b0);
        end
        ramre = 1'b0;

        // Slave stretch of 5 cycles; data only valid once wait drops
        do_acc(16'hE100, 8'h00, 1'b1, 1'b0, 0, 0, 8'hC3, 5,
               mk(7, 6, 1'b0, 2'b01, 16'hE100, 8'h00, 8'hC3, 1'b0, 3'd0));
        // Both strobes high is a write
        do_acc(16'hE002, 8'h5C, 1'b1, 1'b1, 0, 0, 8'h00, 0,
               mk(2, 1, 1'b1, 2'b01, 16'hE002, 8'h5C, 8'hC3, 1'b0, 3'd0));
        // Stuck wait on window 1 -> timeout
        do_acc(16'hF0FF, 8'h00, 1'b1, 1'b0, 1, 2, 8'h77, 1000,
               mk(259, 258, 1'b0, 2'b10, 16'hF0FF, 8'h00, 8'hFF, 1'b1, 3'd1));

        @(posedge clk); #1;
        check("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_cleared", err, 1'b0);
        check("err_win_kept", err_win, 3'd1);

        do_acc(16'hF020, 8'h00, 1'b1, 1'b0, 1, 2, 8'h96, 0,
               mk(4, 3, 1'b0, 2'b10, 16'hF020, 8'h00, 8'h96, 1'b0, 3'd1));

        // Reset in the middle of a stretched access
        @(posedge clk); #1;
        ramadr = 16'hE010; ramre = 1'b1; ext_wait = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        check("mid_access_oe", {ext_cs, ext_oe}, 3'b011);
        nrst = 1'b0;
        #1;
        check("rst_mid_strobes", {ext_cs, ext_oe, ext_we}, 4'b0);
        check("rst_mid_rdata", rdata, 8'h00);
        check("rst_mid_err_win", err_win, 3'd0);
        ramre = 1'b0; ext_wait = '0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        check("post_rst_busy", busy, 1'b0);

        do_acc(16'hE001, 8'h00, 1'b1, 1'b0, 0, 0, 8'h11, 0,
               mk(2, 1, 1'b0, 2'b01, 16'hE001, 8'h00, 8'h11, 1'b0, 3'd0));

        repeat (3) @(posedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_ext_bridge.md
Name: dm_ext_bridge

Overview:
- Multi-window external data-memory bridge between the AVR core's DM master bus (ramadr/ramre/ramwe) and up to NUM_WIN external 8-bit slaves.
- Generalises the single external SRAM window: configurable window count, per-window base, length and fixed wait states, per-slave wait stretching, bus-timeout recovery with a sticky error flag.
- Sits beside avr_interconnect. Its busy output is ORed into core cpuwait; rdata/hit feed the master read mux.

Parameters:
- NUM_WIN, 2, number of external windows (1..8).
- WIN_BASE, {16'hF000,16'hE000}, packed NUM_WIN*16 base addresses; window i = bits [16i+15:16i].
- WIN_LEN, {16'd256,16'd1024}, packed NUM_WIN*16 window lengths in bytes; each >0; base+len ≤ 17'h10000.
- WIN_WS, {4'd2,4'd0}, packed NUM_WIN*4 fixed wait states per window.
- TIMEOUT, 255, max ext_wait stretch cycles before forced completion (1..65535).

Ports:
- clk  in  1  system clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- ramadr  in  16  core DM address.
- ramdout  in  8  core write data.
- ramre  in  1  core read strobe, held while busy.
- ramwe  in  1  core write strobe, held while busy.
- busy  out  1  stall to core (cpuwait contribution).
- hit  out  1  address falls in a window; read-mux select.
- rdata  out  8  read data to core.
- ext_a  out  16  latched address to slaves.
- ext_d_out  out  8  latched write data.
- ext_cs  out  NUM_WIN  one-hot slave select.
- ext_oe  out  1  read strobe.
- ext_we  out  1  write strobe.
- ext_d_in  in  NUM_WIN*8  packed slave read data.
- ext_wait  in  NUM_WIN  per-slave stretch request.
- err  out  1  sticky timeout flag.
- err_win  out  3  index of the window that last timed out.
- err_clr  in  1  clears err; err_win is kept.

Behaviour:
- Reset (async): FSM=IDLE. ext_cs=0, ext_oe=0, ext_we=0, ext_a=0, ext_d_out=0, rdata=0, err=0, err_win=0, counters=0.
- Decode (combinational): window i matches when WIN_BASE[i] ≤ ramadr < WIN_BASE[i]+WIN_LEN[i], compared at 17 bits. If windows overlap, the lowest index wins.
- hit = match on any window AND (ramre|ramwe).
- If ramre and ramwe are both high, the access is a write.
- busy = hit AND state≠DONE (combinational, same cycle as the request).
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on hit, latch ramadr→ext_a, ramdout→ext_d_out, window index, direction; load wscnt=WIN_WS[i] and tcnt=0; go to ACCESS. No hit: remain in IDLE, all outputs quiet.
- ACCESS: ext_cs[i]=1, plus ext_oe (read) or ext_we (write), all registered and stable throughout.
  - If wscnt>0: wscnt decrements each cycle.
  - If wscnt=0 and ext_wait[i]=0: capture ext_d_in[i] into rdata (reads only), go to DONE.
  - If wscnt=0 and ext_wait[i]=1: tcnt increments. When tcnt reaches TIMEOUT: rdata=8'hFF (reads), err=1, err_win=i, go to DONE.
- DONE: strobes and ext_cs deasserted; busy=0 so the core completes this cycle. rdata holds until the next read capture. Next state is IDLE unconditionally.
- Latency with no stretch: a core access sees busy for 2+WIN_WS[i] cycles and completes in the DONE cycle.
- Back-to-back: a new request is evaluated in the IDLE cycle after DONE; minimum spacing is 3 cycles.
- Address or strobes changing during ACCESS are ignored (values are latched).
- err_clr and a timeout in the same cycle: set wins.
- Reset mid-access: strobes drop immediately, no completion is issued, rdata=0.

Test Plan:
- WS=0 read at 16'hE005, ext_d_in[7:0]=8'hA5, ext_wait=0 → busy high 2 cycles; ext_cs=2'b01 and ext_oe high for 1 cycle; rdata=8'hA5 in DONE.
- Write 8'h3C to 16'hF010 (WS=2) → ext_cs=2'b10, ext_we high 3 cycles, ext_a=16'hF010, ext_d_out=8'h3C; busy high 4 cycles.
- Read 16'hE3FF (last byte) and 16'hE400 (first miss) → first is a hit; second gives hit=0, busy=0, no strobes.
- Window 0 with ext_wait[0] held 5 cycles after the WS phase → busy extends by exactly 5 cycles; data captured on the first cycle wait=0; err stays 0.
- ext_wait[1] stuck high, TIMEOUT=255 → completes after 2+2+255 busy cycles; rdata=8'hFF, err=1, err_win=1. Then err_clr pulse → err=0, err_win=1.
- nrst low during ACCESS → ext_cs, ext_oe, ext_we low immediately; after release FSM=IDLE and the next read completes normally.
